mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter NBITS, default 32: datapath and address width.
REQ-002 Reset is asynchronous and active-low; one clock; ports i_clk, i_rst.
REQ-003 i_clk  in  1  rising-edge clock.
REQ-004 i_rst  in  1  asynchronous active-low reset.
REQ-005 i_step  in  1  pipeline advance enable; a new operation is accepted only while high.
REQ-006 i_flg_mem_rd_en / i_flg_mem_wr_en  in  1 each  load / store request from the EX/MA stage register.
REQ-007 i_eff_addr  in  NBITS  byte address.
REQ-008 i_flg_mem_size  in  2  00 byte, 01 half, 11 word; 10 is treated as word.
REQ-009 i_flg_unsign  in  1  zero-extend loads when high, sign-extend when low.
REQ-010 i_wr_data  in  NBITS  store data (rt value), right-aligned.
REQ-011 o_mem_req, o_mem_we  out  1 each  data-memory request and write strobe.
REQ-012 o_mem_addr  out  NBITS-2  word address (i_eff_addr[NBITS-1:2]).
REQ-013 o_mem_wdata  out  NBITS  full-word write data.
REQ-014 i_mem_rdata  in  NBITS, i_mem_ack  in  1  memory read data and completion.
REQ-015 o_rd_data  out  NBITS  extended load result for MA/WB.
REQ-016 o_busy  out  1  stall to the pipeline; high whenever state is not IDLE.
REQ-017 o_done  out  1  one-cycle completion pulse; o_misaligned  out  1  valid with o_done.

Function
REQ-018 FSM states IDLE, READ, WRITE, DONE.
REQ-019 IDLE: on an edge with i_step high, operands are captured and the next state is:
- misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE, o_misaligned=1, no memory request;
- load, or sub-word store -> READ;
- word store -> WRITE.
REQ-020 Store has priority when rd_en and wr_en are both high.
REQ-021 READ: o_mem_req=1, o_mem_we=0. On ack, a load goes to DONE; a sub-word store registers the merged word and goes to WRITE.
REQ-022 WRITE: o_mem_req=1, o_mem_we=1, o_mem_wdata stable. On ack, go to DONE.
REQ-023 DONE: o_done=1 for exactly one cycle, then return to IDLE. A new operation cannot be accepted in DONE.
REQ-024 o_mem_addr, o_mem_we and o_mem_wdata are registered and held constant while o_mem_req is high. i_mem_ack is ignored when o_mem_req is low.
REQ-025 Lanes are little-endian: byte k occupies bits 8k+7:8k; a half at addr[1]=h occupies bits 16h+15:16h.
REQ-026 Store merge replaces only the addressed lane(s) with the low bits of i_wr_data.
REQ-027 Load result: the extracted lane, sign- or zero-extended per i_flg_unsign. A word load passes through unchanged.
REQ-028 o_rd_data updates only on load completion and holds until the next load completes. It is 0 on misaligned loads.
REQ-029 o_misaligned holds its value from capture until the next accept.
REQ-030 i_step low after accept does not abort or pause an operation in flight.
REQ-031 Latency with zero-wait memory (ack in the first request cycle): load 3 cycles accept-to-IDLE; sub-word store 4; word store 3.

Reset
REQ-032 While i_rst is low: state IDLE; all outputs 0, including o_rd_data, o_mem_addr and o_mem_wdata.
REQ-033 Reset mid-transaction drops o_mem_req immediately and produces no o_done.

Structure
REQ-034 A shared defines package holds the mem-size codes (BYTE, HALF, WORD) and the FSM state encodings, and is also used by the EX/MA register and the decoder.
REQ-035 One combinational sub-module, mem_lane_align, performs lane extract/extend and store merge.

Verification
REQ-036 Load byte, addr 0x103, mem word 0x80FF_1234, unsign=0 -> o_rd_data 0xFFFF_FF80; with unsign=1 -> 0x0000_0080.
REQ-037 Store half 0xBEEF to addr 0x42, existing word 0x1122_3344 -> READ then WRITE of 0xBEEF_3344; o_done after the second ack.
REQ-038 Word load at 0x06 -> o_misaligned=1 and o_done after 1 cycle; o_mem_req never asserted; o_rd_data=0.
REQ-039 Ack delayed 5 cycles with i_step toggling -> addr/we/wdata stable throughout; o_busy high until DONE; exactly one o_done.
REQ-040 i_rst low during WRITE -> o_mem_req low asynchronously; state IDLE; a following word store completes normally.
REQ-041 Back-to-back loads with i_step held high -> second accepted only in the cycle after DONE; o_rd_data holds the first result until the second completes.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared memory-access defines: size codes, FSM state encodings and decode helpers.
package mem_access_unit_pkg;

    localparam int unsigned MEM_SIZE_W = 2;
    localparam int unsigned STATE_W    = 2;

    // Access size codes; 2'b10 decodes as a word.
    localparam logic [MEM_SIZE_W-1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [MEM_SIZE_W-1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [MEM_SIZE_W-1:0] MEM_SIZE_WORD = 2'b11;

    // Memory access FSM states.
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_READ  = 2'd1;
    localparam logic [STATE_W-1:0] ST_WRITE = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    // Operand fields captured on accept.
    typedef struct packed {
        logic                  is_store;
        logic [MEM_SIZE_W-1:0] size;
        logic                  unsign;
        logic [1:0]            addr_lo;
    } mem_op_t;

    // Both 2'b11 and 2'b10 are word accesses.
    function automatic logic size_is_word(input logic [MEM_SIZE_W-1:0] size);
        return size[1];
    endfunction

    // Half must be 2-byte aligned, word 4-byte aligned; bytes are always aligned.
    function automatic logic addr_misaligned(input logic [MEM_SIZE_W-1:0] size,
                                             input logic [1:0]            addr_lo);
        logic mis;
        mis = 1'b0;
        if (size_is_word(size)) begin
            mis = (addr_lo != 2'b00);
        end else if (size == MEM_SIZE_HALF) begin
            mis = addr_lo[0];
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned NBITS = 32
) (
    input  logic [1:0]            addr_lo,
    input  logic [MEM_SIZE_W-1:0] size,
    input  logic                  unsign,
    input  logic [NBITS-1:0]      rdata,
    input  logic [NBITS-1:0]      wdata,
    output logic [NBITS-1:0]      ld_data_c,
    output logic [NBITS-1:0]      st_data_c
);

    logic [4:0]       lane_sh;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [NBITS-1:0] lane_mask;

    // Select the addressed lane, extend it for loads and splice store data into the old word.
    always_comb begin
        lane_sh   = (size == MEM_SIZE_HALF) ? {addr_lo[1], 4'b0000} : {addr_lo, 3'b000};
        byte_v    = rdata[lane_sh +: 8];
        half_v    = rdata[lane_sh +: 16];
        lane_mask = '0;
        ld_data_c = rdata;
        st_data_c = wdata;
        if (!size_is_word(size)) begin
            if (size == MEM_SIZE_HALF) begin
                lane_mask = NBITS'(16'hFFFF) << lane_sh;
                ld_data_c = {{(NBITS-16){~unsign & half_v[15]}}, half_v};
                st_data_c = (rdata & ~lane_mask) | ((NBITS'(wdata[15:0]) << lane_sh) & lane_mask);
            end else begin
                lane_mask = NBITS'(8'hFF) << lane_sh;
                ld_data_c = {{(NBITS-8){~unsign & byte_v[7]}}, byte_v};
                st_data_c = (rdata & ~lane_mask) | ((NBITS'(wdata[7:0]) << lane_sh) & lane_mask);
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MA register and a single-port data memory.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned NBITS = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_step,
    input  logic                  i_flg_mem_rd_en,
    input  logic                  i_flg_mem_wr_en,
    input  logic [NBITS-1:0]      i_eff_addr,
    input  logic [MEM_SIZE_W-1:0] i_flg_mem_size,
    input  logic                  i_flg_unsign,
    input  logic [NBITS-1:0]      i_wr_data,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [NBITS-3:0]      o_mem_addr,
    output logic [NBITS-1:0]      o_mem_wdata,
    input  logic [NBITS-1:0]      i_mem_rdata,
    input  logic                  i_mem_ack,
    output logic [NBITS-1:0]      o_rd_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_misaligned
);

    logic [STATE_W-1:0] state_q, state_nxt;
    mem_op_t            op_q, op_nxt;
    logic [NBITS-1:0]   wr_data_q, wr_data_nxt;
    logic [NBITS-3:0]   mem_addr_nxt;
    logic [NBITS-1:0]   mem_wdata_nxt;
    logic [NBITS-1:0]   rd_data_nxt;
    logic               misaligned_nxt;
    logic               mem_req_nxt, mem_we_nxt, busy_nxt, done_nxt;
    logic               mis_c;
    logic [NBITS-1:0]   ld_data_c, st_data_c;

    mem_lane_align #(
        .NBITS (NBITS)
    ) u_lane_align (
        .addr_lo   (op_q.addr_lo),
        .size      (op_q.size),
        .unsign    (op_q.unsign),
        .rdata     (i_mem_rdata),
        .wdata     (wr_data_q),
        .ld_data_c (ld_data_c),
        .st_data_c (st_data_c)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state plus next values of the operand and output registers.
    always_comb begin
        state_nxt      = state_q;
        op_nxt         = op_q;
        wr_data_nxt    = wr_data_q;
        mem_addr_nxt   = o_mem_addr;
        mem_wdata_nxt  = o_mem_wdata;
        rd_data_nxt    = o_rd_data;
        misaligned_nxt = o_misaligned;
        mis_c          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_step && (i_flg_mem_rd_en || i_flg_mem_wr_en)) begin
                    op_nxt.is_store = i_flg_mem_wr_en;
                    op_nxt.size     = i_flg_mem_size;
                    op_nxt.unsign   = i_flg_unsign;
                    op_nxt.addr_lo  = i_eff_addr[1:0];
                    wr_data_nxt     = i_wr_data;
                    mem_addr_nxt    = i_eff_addr[NBITS-1:2];
                    mis_c           = addr_misaligned(i_flg_mem_size, i_eff_addr[1:0]);
                    misaligned_nxt  = mis_c;
                    if (mis_c) begin
                        state_nxt = ST_DONE;
                        if (!i_flg_mem_wr_en) begin
                            rd_data_nxt = '0;
                        end
                    end else if (i_flg_mem_wr_en && size_is_word(i_flg_mem_size)) begin
                        state_nxt     = ST_WRITE;
                        mem_wdata_nxt = i_wr_data;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (i_mem_ack) begin
                    if (op_q.is_store) begin
                        mem_wdata_nxt = st_data_c;
                        state_nxt     = ST_WRITE;
                    end else begin
                        rd_data_nxt = ld_data_c;
                        state_nxt   = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                if (i_mem_ack) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        mem_req_nxt = (state_nxt == ST_READ) || (state_nxt == ST_WRITE);
        mem_we_nxt  = (state_nxt == ST_WRITE);
        busy_nxt    = (state_nxt != ST_IDLE);
        done_nxt    = (state_nxt == ST_DONE);
    end

    // Operand capture and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            op_q         <= '0;
            wr_data_q    <= '0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_rd_data    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            op_q         <= op_nxt;
            wr_data_q    <= wr_data_nxt;
            o_mem_req    <= mem_req_nxt;
            o_mem_we     <= mem_we_nxt;
            o_mem_addr   <= mem_addr_nxt;
            o_mem_wdata  <= mem_wdata_nxt;
            o_rd_data    <= rd_data_nxt;
            o_busy       <= busy_nxt;
            o_done       <= done_nxt;
            o_misaligned <= misaligned_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural data memory.
module tb_mem_access_unit;

    logic        i_clk, i_rst, i_step;
    logic        i_flg_mem_rd_en, i_flg_mem_wr_en;
    logic [31:0] i_eff_addr;
    logic [1:0]  i_flg_mem_size;
    logic        i_flg_unsign;
    logic [31:0] i_wr_data;
    logic        o_mem_req, o_mem_we;
    logic [29:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic [31:0] o_rd_data;
    logic        o_busy, o_done, o_misaligned;

    mem_access_unit #(.NBITS(32)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_step          (i_step),
        .i_flg_mem_rd_en (i_flg_mem_rd_en),
        .i_flg_mem_wr_en (i_flg_mem_wr_en),
        .i_eff_addr      (i_eff_addr),
        .i_flg_mem_size  (i_flg_mem_size),
        .i_flg_unsign    (i_flg_unsign),
        .i_wr_data       (i_wr_data),
        .o_mem_req       (o_mem_req),
        .o_mem_we        (o_mem_we),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdata     (o_mem_wdata),
        .i_mem_rdata     (i_mem_rdata),
        .i_mem_ack       (i_mem_ack),
        .o_rd_data       (o_rd_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_misaligned    (o_misaligned)
    );

    typedef struct { logic mis; logic [31:0] rd; } done_exp_t;
    typedef struct { logic [29:0] a; logic [31:0] d; } wr_exp_t;

    done_exp_t   done_q[$];
    wr_exp_t     wr_q[$];
    logic [31:0] mem [logic [29:0]];

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          ack_delay = 0;
    bit          req_seen = 0;
    logic [31:0] exp_rd = '0;

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every completion pulse is matched against the next expected result.
    always @(negedge i_clk) begin
        if (i_rst && o_done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                done_exp_t e;
                e = done_q.pop_front();
                check("done_misaligned", 32'(o_misaligned), 32'(e.mis));
                check("done_rd_data", o_rd_data, e.rd);
            end
        end
    end

    // Memory responder: acks after ack_delay waiting cycles and checks request stability and writes.
    logic [29:0] snap_addr;
    logic        snap_we;
    logic [31:0] snap_wdata;
    bit          in_req = 0;
    int          wait_cnt = 0;
    always @(negedge i_clk) begin
        if (!i_rst) begin
            i_mem_ack = 1'b0;
            in_req    = 0;
            wait_cnt  = 0;
        end else begin
            if (i_mem_ack) begin
                i_mem_ack = 1'b0;
                in_req    = 0;
                wait_cnt  = 0;
            end
            if (!o_mem_req) begin
                in_req   = 0;
                wait_cnt = 0;
            end else begin
                req_seen = 1;
                if (!in_req) begin
                    in_req     = 1;
                    snap_addr  = o_mem_addr;
                    snap_we    = o_mem_we;
                    snap_wdata = o_mem_wdata;
                end else begin
                    check("stable_addr", 32'(o_mem_addr), 32'(snap_addr));
                    check("stable_we", 32'(o_mem_we), 32'(snap_we));
                    check("stable_wdata", o_mem_wdata, snap_wdata);
                end
                if (wait_cnt >= ack_delay) begin
                    i_mem_ack = 1'b1;
                    if (o_mem_we) begin
                        if (wr_q.size() == 0) begin
                            check("unexpected_write", 32'd1, 32'd0);
                        end else begin
                            wr_exp_t w;
                            w = wr_q.pop_front();
                            check("write_addr", 32'(o_mem_addr), 32'(w.a));
                            check("write_data", o_mem_wdata, w.d);
                        end
                        mem[o_mem_addr] = o_mem_wdata;
                    end else begin
                        i_mem_rdata = mem.exists(o_mem_addr) ? mem[o_mem_addr] : 32'h0;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Issue one operation, push its expectations and wait for the unit to go idle.
    task automatic run_op(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] wd, input logic exp_mis, input logic [31:0] load_val,
                          input logic exp_wr, input logic [31:0] exp_wdata,
                          input int exp_lat, input bit toggle);
        int        cyc;
        int        done0;
        done_exp_t e;
        wr_exp_t   w;
        if (rd && !wr) exp_rd = exp_mis ? 32'h0 : load_val;
        e.mis = exp_mis;
        e.rd  = exp_rd;
        done_q.push_back(e);
        if (exp_wr) begin
            w.a = addr[31:2];
            w.d = exp_wdata;
            wr_q.push_back(w);
        end
        @(negedge i_clk);
        req_seen        = 0;
        done0           = done_cnt;
        i_flg_mem_rd_en = rd;
        i_flg_mem_wr_en = wr;
        i_eff_addr      = addr;
        i_flg_mem_size  = sz;
        i_flg_unsign    = uns;
        i_wr_data       = wd;
        i_step          = 1'b1;
        @(posedge i_clk);
        #1;
        check({name, "_accept_busy"}, 32'(o_busy), 32'd1);
        cyc = 1;
        while (o_busy && cyc < 200) begin
            @(negedge i_clk);
            i_step = toggle ? ~i_step : 1'b0;
            @(posedge i_clk);
            #1;
            cyc++;
        end
        i_step = 1'b0;
        check({name, "_idle"}, 32'(o_busy), 32'd0);
        if (exp_lat > 0) check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        @(negedge i_clk);
        check({name, "_done_count"}, 32'(done_cnt - done0), 32'd1);
        if (exp_mis) check({name, "_no_mem_req"}, 32'(req_seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_clk = 0; i_rst = 0; i_step = 0;
        i_flg_mem_rd_en = 0; i_flg_mem_wr_en = 0;
        i_eff_addr = '0; i_flg_mem_size = 2'b11; i_flg_unsign = 0; i_wr_data = '0;
        i_mem_rdata = '0; i_mem_ack = 0;
        mem[30'h40] = 32'h80FF_1234;
        mem[30'h10] = 32'h1122_3344;
        mem[30'h18] = 32'h1234_5678;
        mem[30'h19] = 32'hCAFE_BABE;

        // Reset state
        #23;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_req", 32'(o_mem_req), 32'd0);
        check("rst_we", 32'(o_mem_we), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_mis", 32'(o_misaligned), 32'd0);
        check("rst_rd_data", o_rd_data, 32'h0);
        check("rst_mem_addr", 32'(o_mem_addr), 32'h0);
        check("rst_mem_wdata", o_mem_wdata, 32'h0);
        @(negedge i_clk);
        i_rst = 1;

        // name rd wr addr size uns wdata mis load_val wr exp_wdata lat toggle
        run_op("lb_s",   1, 0, 32'h103, 2'b00, 0, 32'h0, 0, 32'hFFFF_FF80, 0, 32'h0, 3, 0);
        run_op("lb_u",   1, 0, 32'h103, 2'b00, 1, 32'h0, 0, 32'h0000_0080, 0, 32'h0, 3, 0);
        run_op("lh_s",   1, 0, 32'h102, 2'b01, 0, 32'h0, 0, 32'hFFFF_80FF, 0, 32'h0, 3, 0);
        run_op("lh_u",   1, 0, 32'h100, 2'b01, 1, 32'h0, 0, 32'h0000_1234, 0, 32'h0, 3, 0);
        run_op("lw",     1, 0, 32'h100, 2'b11, 0, 32'h0, 0, 32'h80FF_1234, 0, 32'h0, 3, 0);
        run_op("lw_sz2", 1, 0, 32'h100, 2'b10, 1, 32'h0, 0, 32'h80FF_1234, 0, 32'h0, 3, 0);
        run_op("sh",     0, 1, 32'h042, 2'b01, 0, 32'h0000_BEEF, 0, 32'h0, 1, 32'hBEEF_3344, 4, 0);
        run_op("sb_prio",1, 1, 32'h041, 2'b00, 0, 32'h1234_56A5, 0, 32'h0, 1, 32'hBEEF_A544, 4, 0);
        run_op("lw_mis", 1, 0, 32'h006, 2'b11, 0, 32'h0, 1, 32'h0, 0, 32'h0, 2, 0);
        run_op("lb_ok",  1, 0, 32'h043, 2'b00, 1, 32'h0, 0, 32'h0000_00BE, 0, 32'h0, 3, 0);
        run_op("sh_mis", 0, 1, 32'h043, 2'b01, 0, 32'h0000_FFFF, 1, 32'h0, 0, 32'h0, 2, 0);
        run_op("sw",     0, 1, 32'h020, 2'b11, 0, 32'h0102_0304, 0, 32'h0, 1, 32'h0102_0304, 3, 0);

        // Slow memory with i_step toggling
        ack_delay = 5;
        run_op("sw_slow", 0, 1, 32'h080, 2'b11, 0, 32'hDEAD_BEEF, 0, 32'h0, 1, 32'hDEAD_BEEF, 0, 1);
        run_op("lb_slow", 1, 0, 32'h081, 2'b00, 0, 32'h0, 0, 32'hFFFF_FFBE, 0, 32'h0, 0, 1);
        ack_delay = 0;
        run_op("lw_back", 1, 0, 32'h080, 2'b11, 0, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'h0, 3, 0);

        // Reset during WRITE
        ack_delay = 3;
        begin
            int d0;
            d0 = done_cnt;
            @(negedge i_clk);
            i_flg_mem_rd_en = 0; i_flg_mem_wr_en = 1; i_eff_addr = 32'h084;
            i_flg_mem_size = 2'b11; i_wr_data = 32'h0BAD_F00D; i_step = 1;
            @(posedge i_clk);
            #1;
            check("abort_in_write", 32'(o_mem_we), 32'd1);
            @(negedge i_clk);
            i_step = 0;
            #2;
            i_rst = 0;
            #1;
            check("abort_req_low", 32'(o_mem_req), 32'd0);
            check("abort_busy_low", 32'(o_busy), 32'd0);
            check("abort_rd_data", o_rd_data, 32'h0);
            @(negedge i_clk);
            i_rst = 1;
            exp_rd = 32'h0;
            repeat (4) @(negedge i_clk);
            check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        end
        ack_delay = 0;
        run_op("sw_after", 0, 1, 32'h084, 2'b11, 0, 32'hCAFE_F00D, 0, 32'h0, 1, 32'hCAFE_F00D, 3, 0);
        run_op("lw_after", 1, 0, 32'h084, 2'b11, 0, 32'h0, 0, 32'hCAFE_F00D, 0, 32'h0, 3, 0);

        // Back-to-back loads with i_step held high
        begin
            done_exp_t e;
            int d0;
            d0 = done_cnt;
            e.mis = 0; e.rd = 32'h1234_5678; done_q.push_back(e);
            e.mis = 0; e.rd = 32'h0000_00BA; done_q.push_back(e);
            @(negedge i_clk);
            i_flg_mem_rd_en = 1; i_flg_mem_wr_en = 0; i_eff_addr = 32'h060;
            i_flg_mem_size = 2'b11; i_flg_unsign = 0; i_step = 1;
            @(posedge i_clk); #1;
            check("b2b_first_busy", 32'(o_busy), 32'd1);
            @(negedge i_clk);
            i_eff_addr = 32'h065; i_flg_mem_size = 2'b00; i_flg_unsign = 1;
            @(posedge i_clk); #1;
            check("b2b_first_rd", o_rd_data, 32'h1234_5678);
            @(posedge i_clk); #1;
            check("b2b_not_in_done", 32'(o_busy), 32'd0);
            @(posedge i_clk); #1;
            check("b2b_second_busy", 32'(o_busy), 32'd1);
            check("b2b_rd_hold", o_rd_data, 32'h1234_5678);
            @(negedge i_clk);
            i_step = 0;
            @(posedge i_clk); #1;
            check("b2b_second_rd", o_rd_data, 32'h0000_00BA);
            repeat (3) @(negedge i_clk);
            check("b2b_idle", 32'(o_busy), 32'd0);
            check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
            exp_rd = 32'h0000_00BA;
        end

        check("left_done_exp", 32'(done_q.size()), 32'd0);
        check("left_write_exp", 32'(wr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
